// File: rtl/frame_scheduler_if.sv
// Handshake and write-side bundle between frame_scheduler, the GPU lanes and frame_buffer.
// The master side is the scheduler; the slave side is the GPU / frame buffer pair.
interface frame_scheduler_if #(
  parameter int FMA_COUNT  = 2,
  parameter int ITERS_BITS = 4,
  parameter int COORD_BITS = 32,
  parameter int ADDR_BITS  = 17
);
  logic                            job_valid_out;
  logic                            job_ready_in;
  logic [FMA_COUNT*COORD_BITS-1:0] job_c_re_out;
  logic [FMA_COUNT*COORD_BITS-1:0] job_c_im_out;
  logic                            result_valid_in;
  logic [FMA_COUNT*ITERS_BITS-1:0] result_iters_in;
  logic                            iters_valid_out;
  logic [FMA_COUNT*ITERS_BITS-1:0] iters_out;
  logic [ADDR_BITS-1:0]            addr_write_out;
  logic                            swap_out;

  modport master (
    output job_valid_out, job_c_re_out, job_c_im_out,
    output iters_valid_out, iters_out, addr_write_out, swap_out,
    input  job_ready_in, result_valid_in, result_iters_in
  );

  modport slave (
    input  job_valid_out, job_c_re_out, job_c_im_out,
    input  iters_valid_out, iters_out, addr_write_out, swap_out,
    output job_ready_in, result_valid_in, result_iters_in
  );
endinterface

// File: rtl/frame_scheduler.sv
// Walks the frame column-major, issues FMA_COUNT-lane coordinate batches to the GPU and
// forwards each returned batch to the frame buffer, pulsing swap when a frame is complete.
module frame_scheduler #(
  parameter int FMA_COUNT  = 2,
  parameter int ITERS_BITS = 4,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 320,
  parameter int COORD_BITS = 32
) (
  input  logic                  sys_clk_in,
  input  logic                  rst_n_in,
  input  logic                  run_in,
  input  logic [COORD_BITS-1:0] x_min_in,
  input  logic [COORD_BITS-1:0] y_min_in,
  input  logic [COORD_BITS-1:0] step_in,
  frame_scheduler_if.master     bus,
  output logic                  busy_out,
  output logic [15:0]           frame_count_out
);

  localparam int ADDR_BITS = $clog2(WIDTH*HEIGHT);
  localparam int XB        = $clog2(WIDTH+1);
  localparam int YB        = $clog2(HEIGHT+1);
  localparam int DB        = $clog2(FMA_COUNT+1);
  localparam int IW        = FMA_COUNT*ITERS_BITS;

  localparam logic [XB-1:0]        X_LAST = XB'(WIDTH-1);
  localparam logic [YB-1:0]        Y_LAST = YB'(HEIGHT-FMA_COUNT);
  localparam logic [YB-1:0]        Y_STEP = YB'(FMA_COUNT);
  localparam logic [ADDR_BITS-1:0] A_STEP = ADDR_BITS'(FMA_COUNT);
  localparam logic [DB-1:0]        DRAIN  = DB'(FMA_COUNT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, SWAP} state_t;

  state_t                 state;
  logic [XB-1:0]          x;
  logic [YB-1:0]          y;
  logic [DB-1:0]          drain;
  logic [ADDR_BITS-1:0]   addr_base;
  logic [COORD_BITS-1:0]  c_re;
  logic [COORD_BITS-1:0]  step_r;
  logic [COORD_BITS-1:0]  batch_step;
  logic [COORD_BITS-1:0]  lane_im   [FMA_COUNT];
  logic [COORD_BITS-1:0]  lane_base [FMA_COUNT];
  logic                   job_valid;
  logic                   iters_valid;
  logic [IW-1:0]          iters_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   swap;

  logic [COORD_BITS-1:0]           lane_init [FMA_COUNT];
  logic [COORD_BITS-1:0]           batch_step_new;
  logic [FMA_COUNT*COORD_BITS-1:0] im_packed;
  logic                            start_frame;

  // Lane offsets k*step and the batch stride are built by repeated addition from the live inputs.
  always_comb begin
    logic [COORD_BITS-1:0] lane_acc;
    logic [COORD_BITS-1:0] step_acc;
    lane_acc = y_min_in;
    step_acc = '0;
    for (int k = 0; k < FMA_COUNT; k++) begin
      lane_init[k] = lane_acc;
      lane_acc     = lane_acc + step_in;
      step_acc     = step_acc + step_in;
    end
    batch_step_new = step_acc;
  end

  always_comb begin
    im_packed = '0;
    for (int k = 0; k < FMA_COUNT; k++) begin
      im_packed[(FMA_COUNT-1-k)*COORD_BITS +: COORD_BITS] = lane_im[k];
    end
  end

  assign start_frame = run_in && (state == IDLE || state == SWAP);

  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      drain       <= '0;
      addr_base   <= '0;
      c_re        <= '0;
      step_r      <= '0;
      batch_step  <= '0;
      job_valid   <= 1'b0;
      iters_valid <= 1'b0;
      iters_r     <= '0;
      addr_r      <= '0;
      swap        <= 1'b0;
      busy_out    <= 1'b0;
      frame_count_out <= '0;
      for (int k = 0; k < FMA_COUNT; k++) begin
        lane_im[k]   <= '0;
        lane_base[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: ;
        ISSUE: begin
          if (bus.job_ready_in) begin
            job_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.result_valid_in) begin
            iters_r     <= bus.result_iters_in;
            addr_r      <= addr_base;
            iters_valid <= 1'b1;
            drain       <= DRAIN;
            state       <= WRITE;
          end
        end
        // Hold off the next batch until the frame buffer has serialised every lane.
        WRITE: begin
          iters_valid <= 1'b0;
          if (drain != '0) begin
            drain <= drain - DB'(1);
          end else if (y == Y_LAST) begin
            y <= '0;
            for (int k = 0; k < FMA_COUNT; k++) lane_im[k] <= lane_base[k];
            if (x == X_LAST) begin
              addr_base       <= '0;
              swap            <= 1'b1;
              frame_count_out <= frame_count_out + 16'd1;
              state           <= SWAP;
            end else begin
              x         <= x + XB'(1);
              c_re      <= c_re + step_r;
              addr_base <= addr_base + A_STEP;
              job_valid <= 1'b1;
              state     <= ISSUE;
            end
          end else begin
            y <= y + Y_STEP;
            for (int k = 0; k < FMA_COUNT; k++) lane_im[k] <= lane_im[k] + batch_step;
            addr_base <= addr_base + A_STEP;
            job_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        SWAP: begin
          swap     <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Frame start from IDLE or straight out of SWAP overrides the idle transition above.
      if (start_frame) begin
        x          <= '0;
        y          <= '0;
        addr_base  <= '0;
        c_re       <= x_min_in;
        step_r     <= step_in;
        batch_step <= batch_step_new;
        for (int k = 0; k < FMA_COUNT; k++) begin
          lane_im[k]   <= lane_init[k];
          lane_base[k] <= lane_init[k];
        end
        job_valid <= 1'b1;
        busy_out  <= 1'b1;
        state     <= ISSUE;
      end
    end
  end

  assign bus.job_valid_out   = job_valid;
  assign bus.job_c_re_out    = {FMA_COUNT{c_re}};
  assign bus.job_c_im_out    = im_packed;
  assign bus.iters_valid_out = iters_valid;
  assign bus.iters_out       = iters_r;
  assign bus.addr_write_out  = addr_r;
  assign bus.swap_out        = swap;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed self-checking bench for frame_scheduler on a 4x4 frame with two lanes;
// the GPU answers three cycles after each handshake and expected values come from x/y arithmetic.
module tb_frame_scheduler;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int F  = 2;
  localparam int IB = 4;
  localparam int CB = 32;
  localparam int AB = $clog2(W*H);

  logic          sys_clk_in = 1'b0;
  logic          rst_n_in;
  logic          run_in;
  logic [CB-1:0] x_min_in;
  logic [CB-1:0] y_min_in;
  logic [CB-1:0] step_in;
  logic          busy_out;
  logic [15:0]   frame_count_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  frame_scheduler_if #(.FMA_COUNT(F), .ITERS_BITS(IB), .COORD_BITS(CB), .ADDR_BITS(AB)) bus ();

  frame_scheduler #(
    .FMA_COUNT(F), .ITERS_BITS(IB), .WIDTH(W), .HEIGHT(H), .COORD_BITS(CB)
  ) dut (
    .sys_clk_in      (sys_clk_in),
    .rst_n_in        (rst_n_in),
    .run_in          (run_in),
    .x_min_in        (x_min_in),
    .y_min_in        (y_min_in),
    .step_in         (step_in),
    .bus             (bus),
    .busy_out        (busy_out),
    .frame_count_out (frame_count_out)
  );

  always #5 sys_clk_in = ~sys_clk_in;
  always @(posedge sys_clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_job_valid"}, 64'(bus.job_valid_out), 0);
    checkOutput({tag, "_c_re"}, bus.job_c_re_out, 0);
    checkOutput({tag, "_c_im"}, bus.job_c_im_out, 0);
    checkOutput({tag, "_iters_valid"}, 64'(bus.iters_valid_out), 0);
    checkOutput({tag, "_iters"}, 64'(bus.iters_out), 0);
    checkOutput({tag, "_addr"}, 64'(bus.addr_write_out), 0);
    checkOutput({tag, "_swap"}, 64'(bus.swap_out), 0);
    checkOutput({tag, "_busy"}, 64'(busy_out), 0);
    checkOutput({tag, "_frame_count"}, 64'(frame_count_out), 0);
  endtask

  // Drive frame parameters with run high and advance to the middle of the next cycle.
  task automatic applyStimulus(input logic [CB-1:0] xmin, input logic [CB-1:0] ymin,
                               input logic [CB-1:0] stp);
    x_min_in = xmin;
    y_min_in = ymin;
    step_in  = stp;
    run_in   = 1'b1;
    @(negedge sys_clk_in);
  endtask

  task automatic serveFrame(input logic [CB-1:0] xmin, input logic [CB-1:0] ymin,
                            input logic [CB-1:0] stp, input logic [7:0] itv, input bit vary,
                            input int changeAt, input logic [CB-1:0] newStep, input int dropAt);
    logic [CB-1:0] re, im0, im1;
    logic [7:0]    it;
    int            b, n, lastPulse;
    bit            havePulse;
    havePulse = 1'b0;
    lastPulse = 0;
    for (int x = 0; x < W; x++) begin
      for (int y = 0; y < H; y += F) begin
        b   = x*(H/F) + y/F;
        re  = xmin + stp*32'(x);
        im0 = ymin + stp*32'(y);
        im1 = ymin + stp*32'(y+1);
        it  = vary ? (itv ^ 8'(b*41)) : itv;
        n = 0;
        while (bus.job_valid_out !== 1'b1 && n < 40) begin
          @(negedge sys_clk_in);
          n++;
        end
        checkOutput("job_valid", 64'(bus.job_valid_out), 1);
        checkOutput("busy", 64'(busy_out), 1);
        checkOutput("c_re", bus.job_c_re_out, {re, re});
        checkOutput("c_im", bus.job_c_im_out, {im0, im1});
        @(negedge sys_clk_in);
        checkOutput("job_valid_drop", 64'(bus.job_valid_out), 0);
        repeat (2) @(negedge sys_clk_in);
        bus.result_valid_in = 1'b1;
        bus.result_iters_in = it;
        @(negedge sys_clk_in);
        bus.result_valid_in = 1'b0;
        bus.result_iters_in = 8'hA5;
        checkOutput("iters_valid", 64'(bus.iters_valid_out), 1);
        checkOutput("addr", 64'(bus.addr_write_out), 64'(x*H + y));
        checkOutput("iters", 64'(bus.iters_out), 64'(it));
        if (havePulse) checkOutput("pulse_period", 64'(cyc - lastPulse), 7);
        havePulse = 1'b1;
        lastPulse = cyc;
        @(negedge sys_clk_in);
        checkOutput("iters_valid_pulse", 64'(bus.iters_valid_out), 0);
        checkOutput("iters_hold", 64'(bus.iters_out), 64'(it));
        if (b == changeAt) step_in = newStep;
        if (b == dropAt) run_in = 1'b0;
      end
    end
  endtask

  task automatic finishFrame(input logic [15:0] expCount, input bit expectNext);
    @(negedge sys_clk_in);
    checkOutput("swap_early", 64'(bus.swap_out), 0);
    @(negedge sys_clk_in);
    checkOutput("swap", 64'(bus.swap_out), 1);
    checkOutput("frame_count", 64'(frame_count_out), 64'(expCount));
    @(negedge sys_clk_in);
    checkOutput("swap_pulse", 64'(bus.swap_out), 0);
    checkOutput("next_job_valid", 64'(bus.job_valid_out), 64'(expectNext));
    checkOutput("next_busy", 64'(busy_out), 64'(expectNext));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n_in            = 1'b0;
    run_in              = 1'b1;
    x_min_in            = 32'h1234_5678;
    y_min_in            = 32'h0ABC_DEF0;
    step_in             = 32'h0100_0000;
    bus.job_ready_in    = 1'b1;
    bus.result_valid_in = 1'b0;
    bus.result_iters_in = '0;

    $display("[TB] reset held with run high");
    repeat (3) @(negedge sys_clk_in);
    checkZeroOutputs("reset");
    run_in   = 1'b0;
    rst_n_in = 1'b1;
    repeat (2) @(negedge sys_clk_in);
    checkOutput("idle_busy", 64'(busy_out), 0);
    checkOutput("idle_job_valid", 64'(bus.job_valid_out), 0);

    $display("[TB] frame 1: pulsed run, coordinate walk");
    applyStimulus(32'hE000_0000, 32'hF000_0000, 32'h0800_0000);
    run_in = 1'b0;
    serveFrame(32'hE000_0000, 32'hF000_0000, 32'h0800_0000, 8'h37, 1'b0, -1, '0, -1);
    finishFrame(16'd1, 1'b0);

    $display("[TB] frame 2: stalled ready and stray result in ISSUE");
    bus.job_ready_in = 1'b0;
    applyStimulus(32'h1000_0000, 32'h0000_0000, 32'h0400_0000);
    run_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(bus.job_valid_out), 1);
      checkOutput("stall_c_re", bus.job_c_re_out, {32'h1000_0000, 32'h1000_0000});
      checkOutput("stall_c_im", bus.job_c_im_out, {32'h0000_0000, 32'h0400_0000});
      if (i == 1) begin
        bus.result_valid_in = 1'b1;
        bus.result_iters_in = 8'hC4;
      end
      if (i == 2) begin
        bus.result_valid_in = 1'b0;
        checkOutput("stray_iters_valid", 64'(bus.iters_valid_out), 0);
        checkOutput("stray_addr", 64'(bus.addr_write_out), 14);
        checkOutput("stray_iters", 64'(bus.iters_out), 64'h37);
      end
      @(negedge sys_clk_in);
    end
    bus.job_ready_in = 1'b1;
    serveFrame(32'h1000_0000, 32'h0000_0000, 32'h0400_0000, 8'h5A, 1'b1, -1, '0, -1);
    finishFrame(16'd2, 1'b0);

    $display("[TB] frames 3-4: back to back, step changed mid-frame");
    applyStimulus(32'hF800_0000, 32'h0200_0000, 32'h0080_0000);
    serveFrame(32'hF800_0000, 32'h0200_0000, 32'h0080_0000, 8'h91, 1'b1, 3, 32'h0300_0000, -1);
    finishFrame(16'd3, 1'b1);
    serveFrame(32'hF800_0000, 32'h0200_0000, 32'h0300_0000, 8'h2E, 1'b1, -1, '0, 3);
    finishFrame(16'd4, 1'b0);

    $display("[TB] async reset in WAIT");
    applyStimulus(32'h3000_0000, 32'h2000_0000, 32'h0100_0000);
    checkOutput("pre_reset_valid", 64'(bus.job_valid_out), 1);
    @(negedge sys_clk_in);
    checkOutput("pre_reset_wait_valid", 64'(bus.job_valid_out), 0);
    checkOutput("pre_reset_busy", 64'(busy_out), 1);
    #1 rst_n_in = 1'b0;
    #1 checkZeroOutputs("async_reset");
    @(negedge sys_clk_in);
    bus.job_ready_in = 1'b0;
    rst_n_in         = 1'b1;
    @(negedge sys_clk_in);
    checkOutput("restart_valid", 64'(bus.job_valid_out), 1);
    bus.result_valid_in = 1'b1;
    bus.result_iters_in = 8'hEE;
    @(negedge sys_clk_in);
    bus.result_valid_in = 1'b0;
    checkOutput("late_iters_valid", 64'(bus.iters_valid_out), 0);
    checkOutput("late_addr", 64'(bus.addr_write_out), 0);
    checkOutput("late_iters", 64'(bus.iters_out), 0);
    checkOutput("late_still_issue", 64'(bus.job_valid_out), 1);
    bus.job_ready_in = 1'b1;
    n = 0;
    serveFrame(32'h3000_0000, 32'h2000_0000, 32'h0100_0000, 8'h6B, 1'b1, -1, '0, n);
    finishFrame(16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
